// File: rtl/counter_nd_loop.sv
// Nested loop counter: NUM_DIM dims with carry chain, wrap/saturate end.
// Optional COUNTER_ND_LOOP_ITER_EN adds a saturating iter_cnt output.
module counter_nd_loop #(
  parameter int NUM_DIM = 3,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clean,
  input  logic                     cfg_load,
  input  logic [NUM_DIM*CNT_W-1:0] cfg_bound,
  input  logic                     cfg_wrap,
  input  logic                     en,
  output logic [NUM_DIM*CNT_W-1:0] count,
  output logic [NUM_DIM-1:0]       last,
  output logic                     busy,
  output logic                     done,
`ifdef COUNTER_ND_LOOP_ITER_EN
  output logic [NUM_DIM*CNT_W-1:0] iter_cnt,
`endif
  output logic                     full
);

  localparam int W = NUM_DIM * CNT_W;

  logic [W-1:0]     bnd_q;
  logic             wrap_q;
  logic [NUM_DIM:0] carry;
  logic [W-1:0]     cnt_nxt;
  logic             term;

  always_comb begin
    carry    = '0;
    last     = '0;
    cnt_nxt  = count;
    carry[0] = en & busy;
    for (int d = 0; d < NUM_DIM; d++) begin
      last[d] = count[d*CNT_W +: CNT_W] == bnd_q[d*CNT_W +: CNT_W];
      carry[d+1] = carry[d] & last[d];
      if (carry[d]) begin
        if (last[d])
          cnt_nxt[d*CNT_W +: CNT_W] = '0;
        else
          cnt_nxt[d*CNT_W +: CNT_W] =
            count[d*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
    term = carry[NUM_DIM];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      bnd_q  <= '0;
      wrap_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      full   <= 1'b0;
    end else if (clean) begin
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      full  <= 1'b0;
    end else if (cfg_load) begin
      bnd_q  <= cfg_bound;
      wrap_q <= cfg_wrap;
      count  <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      full   <= 1'b0;
    end else begin
      done <= term;
      // saturate: counts already sit at the bounds, just disarm
      if (term && !wrap_q) begin
        busy <= 1'b0;
        full <= 1'b1;
      end else begin
        count <= cnt_nxt;
      end
    end
  end

`ifdef COUNTER_ND_LOOP_ITER_EN
  always_ff @(posedge clk) begin
    if (rst || clean || cfg_load)
      iter_cnt <= '0;
    else if (carry[0] && iter_cnt != {W{1'b1}})
      iter_cnt <= iter_cnt + W'(1);
  end
`endif

endmodule

// File: tb/tb_counter_nd_loop.sv
// Bench for counter_nd_loop: directed vector table plus
// reference-model scoreboard for the long loop sequences.
module tb_counter_nd_loop;

  localparam int ND = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, clean, cfg_load, cfg_wrap, en;
  logic [11:0]   cfg_bound;
  logic [11:0]   count;
  logic [2:0]    last;
  logic          busy, done, full;
`ifdef COUNTER_ND_LOOP_ITER_EN
  logic [11:0]   iter_cnt;
`endif

  counter_nd_loop #(.NUM_DIM(ND), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clean(clean), .cfg_load(cfg_load),
    .cfg_bound(cfg_bound), .cfg_wrap(cfg_wrap), .en(en),
    .count(count), .last(last), .busy(busy), .done(done),
`ifdef COUNTER_ND_LOOP_ITER_EN
    .iter_cnt(iter_cnt),
`endif
    .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, clean, load;
    logic [11:0] bnd;
    logic        wrap, en;
    logic [11:0] cnt;
    logic [2:0]  lst;
    logic        busy, done, full;
  } vec_t;

  typedef struct {
    logic [11:0] cnt;
    logic [2:0]  lst;
    logic        busy, done, full;
    logic [11:0] iter;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;

  // reference model: linear position inside the mixed-radix space
  int          m_idx;
  logic [11:0] m_bnd;
  bit          m_wrap, m_busy, m_done, m_full;
  logic [11:0] m_iter;

  function automatic int rad(input int d);
    return int'(m_bnd[d*4 +: 4]) + 1;
  endfunction

  function automatic exp_t model_exp();
    exp_t x;
    int   c0, c1, c2;
    c0 = m_idx % rad(0);
    c1 = (m_idx / rad(0)) % rad(1);
    c2 = m_idx / (rad(0) * rad(1));
    x.cnt  = {c2[3:0], c1[3:0], c0[3:0]};
    x.lst  = {c2 == int'(m_bnd[11:8]), c1 == int'(m_bnd[7:4]),
              c0 == int'(m_bnd[3:0])};
    x.busy = m_busy;
    x.done = m_done;
    x.full = m_full;
    x.iter = m_iter;
    return x;
  endfunction

  task automatic model_step(input vec_t v);
    int total;
    if (v.rst) begin
      m_idx = 0; m_bnd = '0; m_wrap = 0; m_busy = 0;
      m_done = 0; m_full = 0; m_iter = '0;
    end else if (v.clean) begin
      m_idx = 0; m_busy = 0; m_done = 0; m_full = 0; m_iter = '0;
    end else if (v.load) begin
      m_bnd = v.bnd; m_wrap = v.wrap; m_idx = 0;
      m_busy = 1; m_done = 0; m_full = 0; m_iter = '0;
    end else begin
      m_done = 0;
      if (v.en && m_busy) begin
        if (m_iter != 12'hfff) m_iter = m_iter + 12'd1;
        total = rad(0) * rad(1) * rad(2);
        if (m_idx == total - 1) begin
          m_done = 1;
          if (m_wrap) m_idx = 0;
          else begin
            m_busy = 0;
            m_full = 1;
          end
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    bit   ok;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    ok = count == e.cnt && last == e.lst && busy == e.busy &&
         done == e.done && full == e.full;
`ifdef COUNTER_ND_LOOP_ITER_EN
    ok = ok && iter_cnt == e.iter;
    if (iter_cnt != e.iter)
      $display("FAIL %s iter: got %h want %h", tag, iter_cnt, e.iter);
`endif
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got cnt=%h last=%b busy=%b done=%b full=%b want cnt=%h last=%b busy=%b done=%b full=%b",
               tag, count, last, busy, done, full,
               e.cnt, e.lst, e.busy, e.done, e.full);
    end
    if (done) n_done++;
  endtask

  // one clock: drive, push expectation, sample 1ns after the edge
  task automatic cyc(input vec_t v, input bit use_tab, input string tag);
    exp_t e;
    rst = v.rst; clean = v.clean; cfg_load = v.load;
    cfg_bound = v.bnd; cfg_wrap = v.wrap; en = v.en;
    model_step(v);
    e = model_exp();
    if (use_tab) begin
      e.cnt = v.cnt; e.lst = v.lst; e.busy = v.busy;
      e.done = v.done; e.full = v.full;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  function automatic vec_t in_v(input logic l, input logic [11:0] b,
                                input logic w, input logic e);
    vec_t v;
    v = '{0, 0, l, b, w, e, 12'h0, 3'b0, 0, 0, 0};
    return v;
  endfunction

  task automatic cmp1(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  vec_t tab[16];

  initial begin
    rst = 1; clean = 0; cfg_load = 0; cfg_wrap = 0; en = 0;
    cfg_bound = '0;
    //          rst cl ld bnd     w  en  cnt     last    bu dn fu
    tab[0]  = '{1, 0, 0, 12'h000, 0, 0, 12'h000, 3'b111, 0, 0, 0};
    tab[1]  = '{0, 0, 0, 12'h000, 0, 1, 12'h000, 3'b111, 0, 0, 0};
    tab[2]  = '{0, 0, 1, 12'h011, 0, 1, 12'h000, 3'b100, 1, 0, 0};
    tab[3]  = '{0, 0, 0, 12'h000, 0, 1, 12'h001, 3'b101, 1, 0, 0};
    tab[4]  = '{0, 0, 0, 12'h000, 0, 1, 12'h010, 3'b110, 1, 0, 0};
    tab[5]  = '{0, 0, 0, 12'h000, 0, 1, 12'h011, 3'b111, 1, 0, 0};
    tab[6]  = '{0, 0, 1, 12'h002, 1, 1, 12'h000, 3'b110, 1, 0, 0};
    tab[7]  = '{0, 0, 0, 12'h000, 0, 1, 12'h001, 3'b110, 1, 0, 0};
    tab[8]  = '{0, 1, 0, 12'h000, 0, 1, 12'h000, 3'b110, 0, 0, 0};
    tab[9]  = '{0, 0, 0, 12'h000, 0, 1, 12'h000, 3'b110, 0, 0, 0};
    tab[10] = '{0, 0, 1, 12'h000, 0, 0, 12'h000, 3'b111, 1, 0, 0};
    tab[11] = '{0, 0, 0, 12'h000, 0, 1, 12'h000, 3'b111, 0, 1, 1};
    tab[12] = '{0, 0, 0, 12'h000, 0, 0, 12'h000, 3'b111, 0, 0, 1};
    tab[13] = '{0, 0, 1, 12'h001, 0, 0, 12'h000, 3'b110, 1, 0, 0};
    tab[14] = '{0, 0, 0, 12'h000, 0, 1, 12'h001, 3'b111, 1, 0, 0};
    tab[15] = '{1, 0, 0, 12'h000, 0, 1, 12'h000, 3'b111, 0, 0, 0};

    for (int i = 0; i < 16; i++)
      cyc(tab[i], 1'b1, $sformatf("vec%0d", i));

    // nested order, saturate: 12 steps then hold at (1,2,1)
    cyc(in_v(1, 12'h121, 0, 0), 0, "nest_load");
    n_done = 0;
    for (int i = 0; i < 15; i++)
      cyc(in_v(0, 12'h0, 0, 1), 0, $sformatf("nest%0d", i));
    cmp1("nest_done_cnt", n_done, 1);
    cmp1("nest_hold", int'(count), 12'h121);
    cmp1("nest_full", int'(full), 1);
`ifdef COUNTER_ND_LOOP_ITER_EN
    cmp1("nest_iter", int'(iter_cnt), 12);
`endif

    // wrap mode, 30 steps
    cyc(in_v(1, 12'h121, 1, 0), 0, "wrap_load");
    n_done = 0;
    for (int i = 0; i < 30; i++)
      cyc(in_v(0, 12'h0, 0, 1), 0, $sformatf("wrap%0d", i));
    cyc(in_v(0, 12'h0, 0, 0), 0, "wrap_idle");
    cmp1("wrap_done_cnt", n_done, 2);
    cmp1("wrap_final", int'(count), 12'h100);
    cmp1("wrap_busy", int'(busy), 1);

    // gapped en with bounds (3,0,0)
    cyc(in_v(1, 12'h003, 0, 0), 0, "gap_load");
    n_done = 0;
    for (int i = 0; i < 10; i++)
      cyc(in_v(0, 12'h0, 0, (i % 2) == 0), 0, $sformatf("gap%0d", i));
    cmp1("gap_done_cnt", n_done, 1);
    cmp1("gap_last12", int'(last[2:1]), 3);

    // maximal bounds: 4096 steps to terminal
    cyc(in_v(1, 12'hfff, 0, 0), 0, "max_load");
    n_done = 0;
    for (int i = 0; i < 4100; i++)
      cyc(in_v(0, 12'h0, 0, 1), 0, $sformatf("max%0d", i));
    cmp1("max_done_cnt", n_done, 1);
    cmp1("max_hold", int'(count), 12'hfff);

    // all-zero bounds in wrap mode: every step terminal
    cyc(in_v(1, 12'h000, 1, 0), 0, "zero_load");
    n_done = 0;
    for (int i = 0; i < 4; i++)
      cyc(in_v(0, 12'h0, 0, 1), 0, $sformatf("zero%0d", i));
    cmp1("zero_done_cnt", n_done, 4);

    cmp1("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
